// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
// Shared types for the fractal synchronization responder.
//   port_state_e : per-child FSM state (IDLE / PEND / RESP)
//   rsp_type_e   : kind of response held towards a child (WAKE / ERROR)
//   rsp_bits()   : maps a response kind onto the {wake, error} output pair
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_RESP = 2'd2
   } port_state_e;

   typedef enum logic {
      RSP_WAKE  = 1'b0,
      RSP_ERROR = 1'b1
   } rsp_type_e;

   // Returns {wake, error}; exactly one bit is set for any legal response.
   function automatic logic [1:0] rsp_bits(input rsp_type_e rsp);
      logic [1:0] bits;
      case (rsp)
         RSP_WAKE:  bits = 2'b10;
         RSP_ERROR: bits = 2'b01;
         default:   bits = 2'b00;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/fractal_sync_rsp_port.sv
// -----------------------------------------------------------------------------
// fractal_sync_rsp_port
// One child link of the responder: FSM, level latch and optional timeout.
// Optional feature macro: FRACTAL_SYNC_RSP_TIMEOUT_EN (pending-cycle timeout).
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   sync_i         : sync request pulse from the child
//   level_i        : requested level, valid with sync_i
//   ack_i          : child acknowledges the held response
//   match_i        : both links pending on the same level (from the top)
//   pend_o         : this link is waiting for its partner
//   level_o        : level latched when the request was accepted
//   wake_o/error_o : registered responses, held until ack_i
// -----------------------------------------------------------------------------
module fractal_sync_rsp_port
   import fractal_sync_pkg::*;
#(
   parameter int LVL_WIDTH = 2,
   parameter int NODE_LVL  = 0,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 sync_i,
   input  logic [LVL_WIDTH-1:0] level_i,
   input  logic                 ack_i,
   input  logic                 match_i,
   output logic                 pend_o,
   output logic [LVL_WIDTH-1:0] level_o,
   output logic                 wake_o,
   output logic                 error_o
);

   localparam logic [LVL_WIDTH-1:0] NODE_LVL_C = LVL_WIDTH'(NODE_LVL);

   // Reject configurations that cannot work at elaboration time.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fractal_sync_rsp_port: TIMEOUT must be at least 1");
   end
   if (NODE_LVL >= (1 << LVL_WIDTH)) begin : g_bad_node_lvl
      $error("fractal_sync_rsp_port: NODE_LVL does not fit in LVL_WIDTH");
   end

   port_state_e          state_r;
   logic [LVL_WIDTH-1:0] lvl_r;
   logic                 wake_r;
   logic                 error_r;
   logic                 expired_s;

`ifdef FRACTAL_SYNC_RSP_TIMEOUT_EN
   localparam int             CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_r;

   assign expired_s = (cnt_r == CNT_MAX);

   // Pending-cycle counter: held at zero outside PEND so it starts from zero
   // on every entry, saturates at the limit (the FSM leaves PEND then).
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != ST_PEND) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (!expired_s) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end
`else
   // Without the timeout a pending link waits for its partner indefinitely.
   assign expired_s = 1'b0;
`endif

   // Link FSM with registered wake/error outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r           <= ST_IDLE;
         lvl_r             <= {LVL_WIDTH{1'b0}};
         {wake_r, error_r} <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sync_i) begin
                  if (level_i == NODE_LVL_C) begin
                     state_r <= ST_PEND;
                     lvl_r   <= level_i;
                  end else begin
                     state_r           <= ST_RESP;
                     {wake_r, error_r} <= rsp_bits(RSP_ERROR);
                  end
               end
            end
            ST_PEND: begin
               // A match in the expiry cycle takes priority over the timeout.
               if (match_i) begin
                  state_r           <= ST_RESP;
                  {wake_r, error_r} <= rsp_bits(RSP_WAKE);
               end else if (expired_s) begin
                  state_r           <= ST_RESP;
                  {wake_r, error_r} <= rsp_bits(RSP_ERROR);
               end
            end
            ST_RESP: begin
               if (ack_i) begin
                  state_r           <= ST_IDLE;
                  {wake_r, error_r} <= 2'b00;
               end
            end
            default: begin
               state_r           <= ST_IDLE;
               {wake_r, error_r} <= 2'b00;
            end
         endcase
      end
   end

   assign pend_o  = (state_r == ST_PEND);
   assign level_o = lvl_r;
   assign wake_o  = wake_r;
   assign error_o = error_r;

endmodule

// File: rtl/fractal_sync_rsp.sv
// -----------------------------------------------------------------------------
// fractal_sync_rsp
// Responder of the fractal synchronization protocol for one tree node. Two
// child links request sync on a level; when both wait on this node's level,
// both receive wake, otherwise the offending child receives error. Responses
// are held until the child acknowledges.
// Optional feature macro: FRACTAL_SYNC_RSP_TIMEOUT_EN (a link waiting more
// than TIMEOUT cycles for its partner is answered with error).
// Ports (bit i / slice i belongs to child i):
//   clk_i, rst_ni : clock, synchronous active-low reset
//   sync_i[1:0]   : sync request pulses
//   level_i       : {level child 1, level child 0}, LVL_WIDTH bits each
//   wake_o[1:0]   : wake grants, held until ack
//   error_o[1:0]  : error responses, held until ack
//   ack_i[1:0]    : acknowledges of the held responses
// -----------------------------------------------------------------------------
module fractal_sync_rsp
   import fractal_sync_pkg::*;
#(
   parameter int LVL_WIDTH = 2,
   parameter int NODE_LVL  = 0,
   parameter int TIMEOUT   = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [1:0]             sync_i,
   input  logic [2*LVL_WIDTH-1:0] level_i,
   output logic [1:0]             wake_o,
   output logic [1:0]             error_o,
   input  logic [1:0]             ack_i
);

   logic [1:0]           pend_s;
   logic [LVL_WIDTH-1:0] lvl0_s;
   logic [LVL_WIDTH-1:0] lvl1_s;
   logic                 match_s;

   // Both links waiting on the same latched level release each other.
   assign match_s = pend_s[0] & pend_s[1] & (lvl0_s == lvl1_s);

   fractal_sync_rsp_port #(
      .LVL_WIDTH (LVL_WIDTH),
      .NODE_LVL  (NODE_LVL),
      .TIMEOUT   (TIMEOUT)
   ) u_port0 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sync_i  (sync_i[0]),
      .level_i (level_i[LVL_WIDTH-1:0]),
      .ack_i   (ack_i[0]),
      .match_i (match_s),
      .pend_o  (pend_s[0]),
      .level_o (lvl0_s),
      .wake_o  (wake_o[0]),
      .error_o (error_o[0])
   );

   fractal_sync_rsp_port #(
      .LVL_WIDTH (LVL_WIDTH),
      .NODE_LVL  (NODE_LVL),
      .TIMEOUT   (TIMEOUT)
   ) u_port1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sync_i  (sync_i[1]),
      .level_i (level_i[2*LVL_WIDTH-1:LVL_WIDTH]),
      .ack_i   (ack_i[1]),
      .match_i (match_s),
      .pend_o  (pend_s[1]),
      .level_o (lvl1_s),
      .wake_o  (wake_o[1]),
      .error_o (error_o[1])
   );

endmodule

// File: tb/tb_fractal_sync_rsp.sv
// -----------------------------------------------------------------------------
// tb_fractal_sync_rsp
// Self-checking bench for fractal_sync_rsp (NODE_LVL = 1, TIMEOUT = 8).
// A per-child behavioural model tracks "waiting since", "answered with wake"
// and "answered with error"; a compare process checks the DUT against it on
// every falling edge. Directed sequences pin the model with literal values,
// then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_fractal_sync_rsp;

   localparam int LW = 2;
   localparam int NL = 1;
   localparam int TO = 8;
`ifdef FRACTAL_SYNC_RSP_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic [1:0]    sync_i = 2'b00;
   logic [2*LW-1:0] level_i = 4'b0000;
   logic [1:0]    ack_i = 2'b00;
   logic [1:0]    wake_o;
   logic [1:0]    error_o;

   int n_cmp = 0;
   int n_bad = 0;

   fractal_sync_rsp #(
      .LVL_WIDTH (LW),
      .NODE_LVL  (NL),
      .TIMEOUT   (TO)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .sync_i  (sync_i),
      .level_i (level_i),
      .wake_o  (wake_o),
      .error_o (error_o),
      .ack_i   (ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b at time %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_wait[2];
   int m_age[2];
   bit m_wake[2];
   bit m_err[2];
   bit chk_en = 1'b0;

   always @(posedge clk) begin
      bit both_wait;
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) begin
            m_wait[i] = 1'b0; m_age[i] = 0; m_wake[i] = 1'b0; m_err[i] = 1'b0;
         end
      end else begin
         both_wait = m_wait[0] && m_wait[1];
         for (int i = 0; i < 2; i++) begin
            if (m_wake[i] || m_err[i]) begin
               if (ack_i[i]) begin
                  m_wake[i] = 1'b0; m_err[i] = 1'b0;
               end
            end else if (m_wait[i]) begin
               if (both_wait) begin
                  m_wake[i] = 1'b1; m_wait[i] = 1'b0;
               end else if (TIMEOUT_ON && m_age[i] == TO) begin
                  m_err[i] = 1'b1; m_wait[i] = 1'b0;
               end else begin
                  m_age[i] = m_age[i] + 1;
               end
            end else if (sync_i[i]) begin
               if (int'(level_i[i*LW +: LW]) == NL) begin
                  m_wait[i] = 1'b1; m_age[i] = 0;
               end else begin
                  m_err[i] = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_wake", wake_o, {m_wake[1], m_wake[0]});
         chk("model_error", error_o, {m_err[1], m_err[0]});
      end
   end

   // One clock cycle of stimulus; returns just after the sampling edge.
   task automatic tick(input logic [1:0] s, input logic [1:0] l0, input logic [1:0] l1,
                       input logic [1:0] a, input logic r = 1'b1);
      @(negedge clk);
      sync_i  = s;
      level_i = {l1, l0};
      ack_i   = a;
      rst_ni  = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b0);
      chk_en = 1'b1;
      tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b0);
      chk("reset_wake", wake_o, 2'b00);
      chk("reset_error", error_o, 2'b00);

      // simultaneous valid syncs: wake two cycles later, ack clears next cycle
      tick(2'b11, 2'd1, 2'd1, 2'b00);
      chk("simul_t1_wake", wake_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("simul_t2_wake", wake_o, 2'b11);
      chk("simul_t2_error", error_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("simul_hold_wake", wake_o, 2'b11);
      tick(2'b00, 2'd0, 2'd0, 2'b11);
      chk("simul_ack_wake", wake_o, 2'b00);

      // staggered syncs: nothing until two cycles after the later sync
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      for (int k = 0; k < 5; k++) begin
         tick(2'b00, 2'd0, 2'd0, 2'b00);
         chk("stagger_wait_wake", wake_o | error_o, 2'b00);
      end
      tick(2'b10, 2'd0, 2'd1, 2'b00);
      chk("stagger_t1_wake", wake_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("stagger_t2_wake", wake_o, 2'b11);
      tick(2'b00, 2'd0, 2'd0, 2'b11);
      chk("stagger_ack_wake", wake_o, 2'b00);

      // invalid level: error next cycle, held until ack, other port unaffected
      tick(2'b01, 2'd2, 2'd0, 2'b00);
      chk("badlvl_error", error_o, 2'b01);
      chk("badlvl_wake", wake_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("badlvl_hold", error_o, 2'b01);
      tick(2'b00, 2'd0, 2'd0, 2'b01);
      chk("badlvl_ack", error_o, 2'b00);
      // error on one port while the other waits
      tick(2'b11, 2'd3, 2'd1, 2'b00);
      chk("mixed_error", error_o, 2'b01);
      chk("mixed_wake", wake_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b01);
      chk("mixed_ack", error_o | wake_o, 2'b00);
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("mixed_wake2", wake_o, 2'b11);
      tick(2'b00, 2'd0, 2'd0, 2'b11);

      // reset while pending drops the request
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00, 1'b0);
      chk("rst_mid_wake", wake_o, 2'b00);
      chk("rst_mid_error", error_o, 2'b00);
      tick(2'b10, 2'd0, 2'd1, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("rst_single_nowake", wake_o | error_o, 2'b00);
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("rst_rejoin_wake", wake_o, 2'b11);
      tick(2'b00, 2'd0, 2'd0, 2'b11);

      // spurious ack in IDLE, extra syncs in PEND and RESP are ignored
      tick(2'b00, 2'd0, 2'd0, 2'b11);
      chk("idle_ack", wake_o | error_o, 2'b00);
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      tick(2'b01, 2'd2, 2'd0, 2'b00);
      chk("pend_resync_error", error_o, 2'b00);
      tick(2'b10, 2'd0, 2'd1, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("extra_wake", wake_o, 2'b11);
      tick(2'b01, 2'd2, 2'd0, 2'b00);
      chk("resp_resync_wake", wake_o, 2'b11);
      chk("resp_resync_error", error_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b11);
      chk("extra_ack", wake_o | error_o, 2'b00);

`ifdef FRACTAL_SYNC_RSP_TIMEOUT_EN
      // silent partner: error after sync + TIMEOUT + 2 cycles
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      for (int k = 0; k < 8; k++) begin
         tick(2'b00, 2'd0, 2'd0, 2'b00);
         chk("tmo_wait_error", error_o, 2'b00);
      end
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("tmo_error", error_o, 2'b01);
      tick(2'b00, 2'd0, 2'd0, 2'b01);
      // partner pending exactly on the expiry cycle: wake wins
      tick(2'b01, 2'd1, 2'd0, 2'b00);
      for (int k = 0; k < 7; k++) tick(2'b00, 2'd0, 2'd0, 2'b00);
      tick(2'b10, 2'd0, 2'd1, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b00);
      chk("tmo_race_wake", wake_o, 2'b11);
      chk("tmo_race_error", error_o, 2'b00);
      tick(2'b00, 2'd0, 2'd0, 2'b11);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            sync_i[i] = ($urandom_range(0, 3) == 0);
            ack_i[i]  = ($urandom_range(0, 2) == 0);
            level_i[i*LW +: LW] = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
         end
         rst_ni = ($urandom_range(0, 199) != 0);
         @(posedge clk);
      end

      @(negedge clk);
      sync_i = 2'b00;
      ack_i  = 2'b00;
      rst_ni = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fractal_sync_rsp.md
# fractal_sync_rsp

Responder end of the fractal synchronization protocol: terminates two child `fractal_if` links at one node of the synchronization tree. It collects `sync` requests from both children and issues `wake` to both when they request the same level and that level matches this node. Otherwise it issues `error`. It holds each response until the child's `ack`. It sits at every tree node configured as the synchronization point for level `NODE_LVL`.

## Interface
- `LVL_WIDTH`, default 2: width of `level`; must match the attached `fractal_if` instances.
- `NODE_LVL`, default 0: level value this node synchronizes; must be below 2^`LVL_WIDTH`.
- `TIMEOUT`, default 1024: pending-cycle limit, used only with the timeout feature; must be ≥ 1.

Ports: `[i]` denotes child i, i ∈ {0,1}. Signals map 1:1 onto the `fractal_if.slv_port` modport.
- `clk_i`  in  1  clock. One clock domain; all state on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `sync_i[i]`  in  1  child i sync request, one-cycle pulse.
- `level_i[i]`  in  LVL_WIDTH  child i level, valid only with `sync_i[i]`.
- `wake_o[i]`  out  1  grant to child i, held until ack.
- `error_o[i]`  out  1  error to child i, held until ack.
- `ack_i[i]`  in  1  child i acknowledges wake/error.

## Operation
- Each port has its own FSM with states IDLE, PEND and RESP.
- **IDLE:**
  - On `sync_i`=1 with `level_i`==`NODE_LVL`: latch level, go to PEND.
  - On `sync_i`=1 with `level_i`≠`NODE_LVL`: go to RESP with error.
- **PEND:**
  - When both ports are in PEND in the same cycle: both go to RESP with wake.
  - `sync_i` arriving in PEND is ignored; it is a protocol violation and is not queued.
- **RESP:**
  - `wake_o` or `error_o` is high, never both.
  - On `ack_i`=1: go to IDLE.
  - `sync_i` arriving in RESP is ignored.
- `ack_i` outside RESP is ignored.
- Ports are independent except for the PEND match. One port may be in RESP/error while the other waits in PEND.

## Timing
- Reset: all FSMs IDLE, counters 0, `wake_o`=`error_o`=0.
- All outputs are registered. There is no combinational path from input to output.
- Error on invalid level: `sync_i` at cycle t → `error_o` high from t+1.
- Simultaneous valid syncs at t → both ports PEND at t+1 → both `wake_o` high from t+2.
  - Staggered syncs: wake goes high two cycles after the later sync.
- `ack_i` at cycle t in RESP → output low and state IDLE at t+1. A new `sync_i` is accepted from t+1.
- Reset asserted mid-operation: next edge returns everything to reset values. Pending requests are dropped and no response is issued.

## Configuration
- Macro: `FRACTAL_SYNC_RSP_TIMEOUT_EN`.
- **Defined:**
  - Each port has a counter of width $clog2(`TIMEOUT`+1). It is cleared on entry to PEND and increments each cycle in PEND.
  - When the count reaches `TIMEOUT` and no match occurs that cycle, the port goes to RESP with error.
  - Match and timeout in the same cycle: the match wins and wake is issued to both.
- **Undefined:** no counter. A port stays in PEND indefinitely until its partner arrives.

## Structure
- `fractal_sync_pkg` holds:
  - the port FSM state enum (IDLE/PEND/RESP);
  - the response-type enum (WAKE/ERROR).
- Sub-module `fractal_sync_rsp_port`: one port's FSM, level latch and optional timeout counter.
  - Instantiated twice.
- The top level holds:
  - the match logic (both PEND, latched levels equal);
  - the glue between the two port instances.

## Test plan
- `NODE_LVL`=1. Both `sync_i`=1 with `level_i`=1 at cycle 5 → both `wake_o` high at cycle 7. Ack both at cycle 9 → both outputs low at cycle 10.
- Port 0 sync at cycle 3 (level 1), port 1 sync at cycle 12 (level 1) → both wakes at cycle 14. No output before cycle 14.
- Port 0 sync with `level_i`=2 (`NODE_LVL`=1) at cycle 4 → `error_o[0]` at cycle 5, held until ack. Port 1 is unaffected.
- Reset low at cycle 6 while port 0 is PEND → all outputs 0 at cycle 7. A later single sync produces no wake.
- With `FRACTAL_SYNC_RSP_TIMEOUT_EN`, `TIMEOUT`=8: port 0 sync at cycle 0, partner silent → `error_o[0]` high at cycle 10.
  - Partner sync arriving exactly on the expiry cycle → wake on both instead of error.
- Extra `sync_i[0]` pulses during PEND and RESP, and `ack_i` while IDLE → no state change and no spurious response.
